// File: rtl/pulse_spacer_pkg.sv
// Shared types for pulse_spacer.
// Holds the spacer FSM state encoding; parameters stay local to the module.
package pulse_spacer_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StEmit    = 2'd1,
        StHoldoff = 2'd2
    } state_e;

endpackage

// File: rtl/pulse_spacer.sv
// pulse_spacer: buffers single-cycle input events and replays them as single-cycle
// output pulses whose rising edges are at least MIN_SPACING cycles apart, so they
// can feed a pulse_synchronizer directly.
//
// Ports:
//   clock          - single clock, rising edge
//   resetn         - asynchronous active-low reset
//   pulse_in       - each high cycle is one event
//   overflow_clear - clears the sticky overflow flag (a same-cycle drop wins)
//   pulse_out      - registered single-cycle output pulse
//   pending        - events accepted but not yet emitted
//   busy           - FSM not idle or events pending
//   overflow       - sticky, set once any event has been dropped
module pulse_spacer
    import pulse_spacer_pkg::*;
#(
    parameter int unsigned MIN_SPACING   = 4,
    parameter int unsigned COUNTER_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     pulse_in,
    input  logic                     overflow_clear,
    output logic                     pulse_out,
    output logic [COUNTER_WIDTH-1:0] pending,
    output logic                     busy,
    output logic                     overflow
);

    localparam int unsigned HoldWidth = (MIN_SPACING > 2) ? $clog2(MIN_SPACING) : 1;
    // Holdoff counts this value down to zero, giving MIN_SPACING-1 holdoff cycles.
    localparam logic [HoldWidth-1:0] HoldLoad = HoldWidth'(MIN_SPACING - 2);
    localparam logic [COUNTER_WIDTH-1:0] PendMax = '1;

    state_e                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] pending_q, pending_d;
    logic [HoldWidth-1:0]     hold_q, hold_d;
    logic                     pulse_q;
    logic                     overflow_q, overflow_d;
    logic                     accept, emit, drop;

    // A full counter still accepts while emitting, since the emit frees a slot.
    assign emit      = (state_q == StEmit);
    assign accept    = pulse_in && !((pending_q == PendMax) && !emit);
    assign drop      = pulse_in && !accept;
    assign pending_d = pending_q + COUNTER_WIDTH'(accept) - COUNTER_WIDTH'(emit);

    assign overflow_d = drop ? 1'b1 : (overflow_clear ? 1'b0 : overflow_q);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if ((pending_q != '0) || pulse_in) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                state_d = StHoldoff;
                hold_d  = HoldLoad;
            end
            StHoldoff: begin
                if (hold_q == '0) begin
                    state_d = (pending_d != '0) ? StEmit : StIdle;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            hold_q     <= '0;
            pulse_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            hold_q     <= hold_d;
            // Dedicated flop mirrors the EMIT state so pulse_out is glitch-free.
            pulse_q    <= (state_d == StEmit);
            overflow_q <= overflow_d;
        end
    end

    assign pulse_out = pulse_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != StIdle) || (pending_q != '0);

endmodule
